// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation encodings and operand-select types
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b1000,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_SLL  = 4'b0001,
      ALU_SRA  = 4'b1101,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_LUI  = 4'b1001
   } alu_fun_t;

   typedef enum logic [1:0] {
      SRCA_RS1   = 2'd0,
      SRCA_IMM_U = 2'd1,
      SRCA_PC    = 2'd2,
      SRCA_ZERO  = 2'd3
   } srca_sel_t;

   typedef enum logic [1:0] {
      SRCB_RS2   = 2'd0,
      SRCB_IMM_I = 2'd1,
      SRCB_IMM_S = 2'd2,
      SRCB_FOUR  = 2'd3
   } srcb_sel_t;

   localparam int OPERAND_FOUR = 4;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - source operand resolver; bypass network only with ALU_ISSUE_FWD_EN
module fwd_mux
   import alu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] addr,
   input  logic [XLEN-1:0]   rf_data,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic              exmem_we,
   input  logic [XLEN-1:0]   exmem_result,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic              memwb_we,
   input  logic [XLEN-1:0]   memwb_result,
   output logic [XLEN-1:0]   data
);

`ifdef ALU_ISSUE_FWD_EN
   // Younger producer (EX/MEM) shadows the older one (MEM/WB).
   always_comb begin
      data = rf_data;
      if (addr == '0)
         data = '0;
      else if (exmem_we && (exmem_rd == addr))
         data = exmem_result;
      else if (memwb_we && (memwb_rd == addr))
         data = memwb_result;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{exmem_rd, exmem_we, exmem_result, memwb_rd, memwb_we, memwb_result};
   assign data       = (addr == '0) ? '0 : rf_data;
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX issue register feeding the ALU; forwarding via ALU_ISSUE_FWD_EN
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              FLUSH,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [XLEN-1:0]   RS1_DATA,
   input  logic [XLEN-1:0]   RS2_DATA,
   input  logic [REG_AW-1:0] RS1_ADDR,
   input  logic [REG_AW-1:0] RS2_ADDR,
   input  logic [XLEN-1:0]   PC,
   input  logic [XLEN-1:0]   IMM_I,
   input  logic [XLEN-1:0]   IMM_S,
   input  logic [XLEN-1:0]   IMM_U,
   input  logic [1:0]        SRCA_SEL,
   input  logic [1:0]        SRCB_SEL,
   input  logic [3:0]        ALU_FUN_IN,
   input  logic [REG_AW-1:0] RD_ADDR,
   input  logic              REG_WE,
   input  logic [REG_AW-1:0] EXMEM_RD,
   input  logic              EXMEM_WE,
   input  logic [XLEN-1:0]   EXMEM_RESULT,
   input  logic [REG_AW-1:0] MEMWB_RD,
   input  logic              MEMWB_WE,
   input  logic [XLEN-1:0]   MEMWB_RESULT,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [XLEN-1:0]   ALU_A,
   output logic [XLEN-1:0]   ALU_B,
   output logic [3:0]        ALU_FUN,
   output logic [REG_AW-1:0] RD_OUT,
   output logic              REG_WE_OUT,
   output logic [XLEN-1:0]   PC_OUT,
   output logic [XLEN-1:0]   STORE_DATA
);

   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;
   logic [XLEN-1:0] alu_a_nxt;
   logic [XLEN-1:0] alu_b_nxt;
   logic            reg_we_q;
   logic            capture;

   fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
      .addr(RS1_ADDR), .rf_data(RS1_DATA),
      .exmem_rd(EXMEM_RD), .exmem_we(EXMEM_WE), .exmem_result(EXMEM_RESULT),
      .memwb_rd(MEMWB_RD), .memwb_we(MEMWB_WE), .memwb_result(MEMWB_RESULT),
      .data(rs1_fwd)
   );

   fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
      .addr(RS2_ADDR), .rf_data(RS2_DATA),
      .exmem_rd(EXMEM_RD), .exmem_we(EXMEM_WE), .exmem_result(EXMEM_RESULT),
      .memwb_rd(MEMWB_RD), .memwb_we(MEMWB_WE), .memwb_result(MEMWB_RESULT),
      .data(rs2_fwd)
   );

   always_comb begin
      alu_a_nxt = rs1_fwd;
      case (srca_sel_t'(SRCA_SEL))
         SRCA_RS1:   alu_a_nxt = rs1_fwd;
         SRCA_IMM_U: alu_a_nxt = IMM_U;
         SRCA_PC:    alu_a_nxt = PC;
         SRCA_ZERO:  alu_a_nxt = '0;
      endcase
   end

   always_comb begin
      alu_b_nxt = rs2_fwd;
      case (srcb_sel_t'(SRCB_SEL))
         SRCB_RS2:   alu_b_nxt = rs2_fwd;
         SRCB_IMM_I: alu_b_nxt = IMM_I;
         SRCB_IMM_S: alu_b_nxt = IMM_S;
         SRCB_FOUR:  alu_b_nxt = XLEN'(OPERAND_FOUR);
      endcase
   end

   assign IN_READY   = !OUT_VALID || OUT_READY;
   assign capture    = IN_VALID && IN_READY && !FLUSH;
   assign REG_WE_OUT = reg_we_q && OUT_VALID;

   // Data registers only move on capture, so a stalled entry stays bit-exact.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         OUT_VALID  <= 1'b0;
         ALU_A      <= '0;
         ALU_B      <= '0;
         ALU_FUN    <= ALU_ADD;
         RD_OUT     <= '0;
         reg_we_q   <= 1'b0;
         PC_OUT     <= '0;
         STORE_DATA <= '0;
      end else begin
         if (FLUSH)
            OUT_VALID <= 1'b0;
         else if (capture)
            OUT_VALID <= 1'b1;
         else if (OUT_READY)
            OUT_VALID <= 1'b0;

         if (capture) begin
            ALU_A      <= alu_a_nxt;
            ALU_B      <= alu_b_nxt;
            ALU_FUN    <= ALU_FUN_IN;
            RD_OUT     <= RD_ADDR;
            reg_we_q   <= REG_WE;
            PC_OUT     <= PC;
            STORE_DATA <= rs2_fwd;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - randomized self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

`ifdef ALU_ISSUE_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic              in_ready, out_valid, reg_we_out;
   logic [XLEN-1:0]   rs1_data = '0, rs2_data = '0, pc = '0, imm_i = '0, imm_s = '0, imm_u = '0;
   logic [REG_AW-1:0] rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
   logic [1:0]        srca_sel = '0, srcb_sel = '0;
   logic [3:0]        alu_fun_in = '0;
   logic              reg_we = 1'b0;
   logic [REG_AW-1:0] exmem_rd = '0, memwb_rd = '0;
   logic              exmem_we = 1'b0, memwb_we = 1'b0;
   logic [XLEN-1:0]   exmem_result = '0, memwb_result = '0;
   logic [XLEN-1:0]   alu_a, alu_b, pc_out, store_data;
   logic [3:0]        alu_fun;
   logic [REG_AW-1:0] rd_out;

   int errors = 0;
   int checks = 0;

   // Reference model: the instruction the stage should currently be holding.
   logic              m_valid, m_we;
   logic [XLEN-1:0]   m_a, m_b, m_pc, m_sd;
   logic [3:0]        m_fun;
   logic [REG_AW-1:0] m_rd;

   alu_issue_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
      .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready),
      .RS1_DATA(rs1_data), .RS2_DATA(rs2_data), .RS1_ADDR(rs1_addr), .RS2_ADDR(rs2_addr),
      .PC(pc), .IMM_I(imm_i), .IMM_S(imm_s), .IMM_U(imm_u),
      .SRCA_SEL(srca_sel), .SRCB_SEL(srcb_sel), .ALU_FUN_IN(alu_fun_in),
      .RD_ADDR(rd_addr), .REG_WE(reg_we),
      .EXMEM_RD(exmem_rd), .EXMEM_WE(exmem_we), .EXMEM_RESULT(exmem_result),
      .MEMWB_RD(memwb_rd), .MEMWB_WE(memwb_we), .MEMWB_RESULT(memwb_result),
      .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .ALU_A(alu_a), .ALU_B(alu_b), .ALU_FUN(alu_fun), .RD_OUT(rd_out),
      .REG_WE_OUT(reg_we_out), .PC_OUT(pc_out), .STORE_DATA(store_data)
   );

   always #5 clk = ~clk;

   function automatic logic [XLEN-1:0] source_value(input logic [REG_AW-1:0] addr,
                                                     input logic [XLEN-1:0] rf);
      if (addr == 0) return '0;
      if (FWD_EN && exmem_we && exmem_rd == addr) return exmem_result;
      if (FWD_EN && memwb_we && memwb_rd == addr) return memwb_result;
      return rf;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_we = 1'b0; m_a = '0; m_b = '0; m_pc = '0; m_sd = '0; m_fun = '0; m_rd = '0;
   endtask

   // Advance the model with the current inputs, clock once, settle at the falling edge.
   task automatic tick();
      logic [XLEN-1:0] a_choice [4];
      logic [XLEN-1:0] b_choice [4];
      logic            accept;
      a_choice = '{source_value(rs1_addr, rs1_data), imm_u, pc, 32'd0};
      b_choice = '{source_value(rs2_addr, rs2_data), imm_i, imm_s, 32'd4};
      accept   = in_valid && (!m_valid || out_ready);
      if (flush) begin
         m_valid = 1'b0;
      end else if (accept) begin
         m_valid = 1'b1;
         m_a = a_choice[srca_sel];
         m_b = b_choice[srcb_sel];
         m_fun = alu_fun_in;
         m_rd = rd_addr;
         m_we = reg_we;
         m_pc = pc;
         m_sd = source_value(rs2_addr, rs2_data);
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic randomize_inputs();
      rs1_data = $urandom; rs2_data = $urandom; pc = $urandom;
      imm_i = $urandom; imm_s = $urandom; imm_u = $urandom;
      rs1_addr = REG_AW'($urandom_range(0, 3)); rs2_addr = REG_AW'($urandom_range(0, 3));
      rd_addr = REG_AW'($urandom); reg_we = 1'($urandom);
      srca_sel = 2'($urandom); srcb_sel = 2'($urandom); alu_fun_in = 4'($urandom);
      exmem_rd = REG_AW'($urandom_range(0, 3)); exmem_we = 1'($urandom); exmem_result = $urandom;
      memwb_rd = REG_AW'($urandom_range(0, 3)); memwb_we = 1'($urandom); memwb_result = $urandom;
   endtask

   task automatic test_reset();
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
      checks++; if ({alu_a, alu_b, pc_out, store_data} !== '0) begin errors++; $display("FAIL reset_data a=%h b=%h pc=%h sd=%h exp=0", alu_a, alu_b, pc_out, store_data); end
      checks++; if ({alu_fun, rd_out, reg_we_out} !== '0) begin errors++; $display("FAIL reset_ctrl fun=%h rd=%h we=%b exp=0", alu_fun, rd_out, reg_we_out); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_forward();
      logic [XLEN-1:0] exp_a;
      randomize_inputs();
      in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
      rs1_addr = 5; rs1_data = 32'h10; srca_sel = 2'd0;
      exmem_rd = 5; exmem_we = 1'b1; exmem_result = 32'hAA;
      memwb_rd = 5; memwb_we = 1'b1; memwb_result = 32'hBB;
      tick();
      exp_a = FWD_EN ? 32'hAA : 32'h10;
      checks++; if (alu_a !== exp_a) begin errors++; $display("FAIL fwd_exmem got=%h exp=%h", alu_a, exp_a); end
      exmem_we = 1'b0;
      tick();
      exp_a = FWD_EN ? 32'hBB : 32'h10;
      checks++; if (alu_a !== exp_a) begin errors++; $display("FAIL fwd_memwb got=%h exp=%h", alu_a, exp_a); end
      memwb_we = 1'b0;
      tick();
      checks++; if (alu_a !== 32'h10) begin errors++; $display("FAIL fwd_rf got=%h exp=10", alu_a); end
   endtask

   task automatic test_x0();
      rs2_addr = 0; rs2_data = 32'h1234_5678; srcb_sel = 2'd0;
      exmem_rd = 0; exmem_we = 1'b1; exmem_result = 32'hFF;
      memwb_rd = 0; memwb_we = 1'b1; memwb_result = 32'hEE;
      tick();
      checks++; if (alu_b !== '0) begin errors++; $display("FAIL x0_alu_b got=%h exp=0", alu_b); end
      checks++; if (store_data !== '0) begin errors++; $display("FAIL x0_store got=%h exp=0", store_data); end
   endtask

   task automatic test_sel();
      srca_sel = 2'd2; pc = 32'h100; srcb_sel = 2'd3; alu_fun_in = 4'b0000;
      rs2_addr = 3; rs2_data = 32'hCAFE_0003; exmem_we = 1'b0; memwb_we = 1'b0;
      tick();
      checks++; if (alu_a !== 32'h100) begin errors++; $display("FAIL sel_pc got=%h exp=100", alu_a); end
      checks++; if (alu_b !== 32'd4) begin errors++; $display("FAIL sel_four got=%h exp=4", alu_b); end
      checks++; if (alu_fun !== 4'b0000) begin errors++; $display("FAIL sel_fun got=%h exp=0", alu_fun); end
      checks++; if (store_data !== 32'hCAFE_0003) begin errors++; $display("FAIL sel_store got=%h exp=cafe0003", store_data); end
   endtask

   task automatic test_hold();
      logic [XLEN-1:0]   s_a, s_b, s_pc, s_sd;
      logic [3:0]        s_fun;
      logic [REG_AW-1:0] s_rd;
      logic              s_we;
      randomize_inputs();
      in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0; reg_we = 1'b1;
      tick();
      s_a = m_a; s_b = m_b; s_pc = m_pc; s_sd = m_sd; s_fun = m_fun; s_rd = m_rd; s_we = m_we;
      for (int i = 0; i < 3; i++) begin
         randomize_inputs();
         out_ready = 1'b0; in_valid = 1'b1;
         #1;
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc=%0d got=%0b exp=0", i, in_ready); end
         tick();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc=%0d got=%0b exp=1", i, out_valid); end
         checks++;
         if ({alu_a, alu_b, pc_out, store_data, alu_fun, rd_out, reg_we_out} !== {s_a, s_b, s_pc, s_sd, s_fun, s_rd, s_we}) begin
            errors++;
            $display("FAIL hold_frozen cyc=%0d a=%h/%h b=%h/%h pc=%h/%h sd=%h/%h fun=%h/%h rd=%h/%h we=%b/%b",
                     i, alu_a, s_a, alu_b, s_b, pc_out, s_pc, store_data, s_sd, alu_fun, s_fun, rd_out, s_rd, reg_we_out, s_we);
         end
      end
      randomize_inputs();
      out_ready = 1'b1; in_valid = 1'b1; srca_sel = 2'd2; pc = ~s_pc;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%0b exp=1", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL release_valid got=%0b exp=1", out_valid); end
      checks++; if (alu_a !== ~s_pc || pc_out !== ~s_pc) begin errors++; $display("FAIL release_capture a=%h pc=%h exp=%h", alu_a, pc_out, ~s_pc); end
   endtask

   task automatic test_flush();
      randomize_inputs();
      in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0; reg_we = 1'b1;
      tick();
      randomize_inputs();
      reg_we = 1'b1; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
      checks++; if (reg_we_out !== 1'b0) begin errors++; $display("FAIL flush_we got=%0b exp=0", reg_we_out); end
      flush = 1'b0; in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%0b exp=0", out_valid); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         randomize_inputs();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 7) == 0);
         #1;
         checks++; if (in_ready !== (!m_valid || out_ready)) begin errors++; $display("FAIL rand_in_ready cyc=%0d got=%0b exp=%0b", i, in_ready, !m_valid || out_ready); end
         tick();
         checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", i, out_valid, m_valid); end
         checks++; if (reg_we_out !== (m_we && m_valid)) begin errors++; $display("FAIL rand_we cyc=%0d got=%0b exp=%0b", i, reg_we_out, m_we && m_valid); end
         if (m_valid) begin
            checks++;
            if ({alu_a, alu_b, pc_out, store_data, alu_fun, rd_out} !== {m_a, m_b, m_pc, m_sd, m_fun, m_rd}) begin
               errors++;
               $display("FAIL rand_data cyc=%0d a=%h/%h b=%h/%h pc=%h/%h sd=%h/%h fun=%h/%h rd=%h/%h",
                        i, alu_a, m_a, alu_b, m_b, pc_out, m_pc, store_data, m_sd, alu_fun, m_fun, rd_out, m_rd);
            end
         end
      end
      flush = 1'b0;
   endtask

   task automatic test_reset_mid_hold();
      randomize_inputs();
      in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0; reg_we = 1'b1; pc = 32'hDEAD_BEEF;
      tick();
      out_ready = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_valid got=%0b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_in_ready got=%0b exp=1", in_ready); end
      checks++; if ({alu_a, alu_b, pc_out, store_data, alu_fun, rd_out, reg_we_out} !== '0) begin errors++; $display("FAIL async_data a=%h b=%h pc=%h sd=%h fun=%h exp=0", alu_a, alu_b, pc_out, store_data, alu_fun); end
      in_valid = 1'b0;
      model_reset();
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got=%0b exp=0", out_valid); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_forward();
      test_x0();
      test_sel();
      test_hold();
      test_flush();
      test_random();
      test_reset_mid_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX issue register directly upstream of the ALU. Selects and forwards operands, then registers the ALU operands, the 4-bit ALU_FUN and the writeback tag. Presents them to the ALU and to the EX/MEM stage with a one-entry valid/ready handshake. Supports stall (backpressure) and flush (branch/jump squash).

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
FLUSH  in  1  squash held and incoming instruction
IN_VALID  in  1  decode has an instruction
IN_READY  out  1  stage accepts this cycle
RS1_DATA, RS2_DATA  in  XLEN  register-file read data
RS1_ADDR, RS2_ADDR  in  REG_AW  source register numbers
PC  in  XLEN  instruction address
IMM_I, IMM_S, IMM_U  in  XLEN  pre-extended immediates
SRCA_SEL  in  2  0=rs1, 1=IMM_U, 2=PC, 3=zero
SRCB_SEL  in  2  0=rs2, 1=IMM_I, 2=IMM_S, 3=constant 4
ALU_FUN_IN  in  4  ALU operation encoding
RD_ADDR  in  REG_AW  destination register
REG_WE  in  1  instruction writes rd
EXMEM_RD  in  REG_AW  EX/MEM destination
EXMEM_WE  in  1  EX/MEM writes rd
EXMEM_RESULT  in  XLEN  EX/MEM result
MEMWB_RD  in  REG_AW  MEM/WB destination
MEMWB_WE  in  1  MEM/WB writes rd
MEMWB_RESULT  in  XLEN  MEM/WB result
OUT_VALID  out  1  registered instruction is valid
OUT_READY  in  1  downstream consumes this cycle
ALU_A, ALU_B  out  XLEN  registered ALU operands
ALU_FUN  out  4  registered ALU operation
RD_OUT  out  REG_AW  registered destination
REG_WE_OUT  out  1  registered write enable, forced 0 when OUT_VALID=0
PC_OUT  out  XLEN  registered PC
STORE_DATA  out  XLEN  registered forwarded rs2 value

Behaviour:
- Reset (RST_N low, asynchronous): OUT_VALID=0. All data outputs 0. ALU_FUN=4'b0000 (add). Takes effect immediately, even mid-stall.
- IN_READY = !OUT_VALID || OUT_READY. Purely combinational; it must not depend on IN_VALID.
- Capture: IN_VALID && IN_READY && !FLUSH loads all registers on the next edge and sets OUT_VALID=1. Latency is 1 cycle from decode to ALU inputs.
- Drain: OUT_VALID && OUT_READY with no capture clears OUT_VALID.
- Hold: OUT_VALID && !OUT_READY freezes every output bit-exact.
- FLUSH wins over everything except reset. On the next edge OUT_VALID=0 and REG_WE_OUT=0, whatever IN_VALID or OUT_READY are.
- Forwarding, per source (rs1, rs2), evaluated at capture only:
  - Addr==0 gives 0.
  - Else if EXMEM_WE && EXMEM_RD==addr, use EXMEM_RESULT.
  - Else if MEMWB_WE && MEMWB_RD==addr, use MEMWB_RESULT.
  - Else use register-file data.
  - EX/MEM has priority over MEM/WB.
- Operands are not re-forwarded while holding; the hazard unit guarantees producers stall with this stage.
- SRCA_SEL/SRCB_SEL apply after forwarding. STORE_DATA is always the forwarded rs2, independent of SRCB_SEL.
- Sel encoding 3 on A yields 0. On B it yields 32'd4.
- All arithmetic is pass-through. Immediates are not re-extended here.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN.
- Defined: forwarding network as above.
- Undefined: the forwarding mux is removed and RS1_DATA/RS2_DATA (x0 still 0) feed operand select. The EX/MEM and MEM/WB ports remain but are ignored, so a single-issue non-pipelined build still links.

Decomposition:
- Shared package alu_pkg:
  - ALU operation enum: add 0000, sub 1000, or 0110, and 0111, xor 0100, srl 0101, sll 0001, sra 1101, slt 0010, sltu 0011, lui 1001.
  - srca_sel_t and srcb_sel_t enums.
  - Constant for the +4 operand.
- One sub-module, fwd_mux: combinational source resolver instantiated twice (rs1, rs2). Compiled to a pass-through without ALU_ISSUE_FWD_EN.

Test Plan:
- Reset pulse mid-hold with OUT_VALID=1 -> outputs go 0 asynchronously; OUT_VALID=0 before the next edge; IN_READY=1.
- RS1_ADDR=5, RS1_DATA=0x10, EXMEM_RD=5/WE=1/RESULT=0xAA, MEMWB_RD=5/WE=1/RESULT=0xBB, SRCA_SEL=0 -> ALU_A=0xAA one cycle later. Repeat with EXMEM_WE=0 -> 0xBB.
- RS2_ADDR=0, EXMEM_RD=0/WE=1/RESULT=0xFF, SRCB_SEL=0 -> ALU_B=0 and STORE_DATA=0.
- SRCA_SEL=2, PC=0x100, SRCB_SEL=3, ALU_FUN_IN=0000 -> ALU_A=0x100, ALU_B=4, ALU_FUN=0000.
- Capture, then OUT_READY=0 for 3 cycles while inputs change -> outputs unchanged and IN_READY=0. Then OUT_READY=1 with IN_VALID=1 -> new instruction captured the same edge, OUT_VALID stays 1.
- FLUSH=1 together with IN_VALID=1 and OUT_VALID=1 -> next cycle OUT_VALID=0, REG_WE_OUT=0; the incoming instruction is dropped.
